link_arbiter: RTL and testbench
===============================

# link_arbiter

Transmit-side arbiter that shares one 4-phase bundled-data link between NUM_SRC local requesters. It selects a requester round-robin, drives that requester's word and the link request, synchronizes the returning acknowledge through two flops, and completes the full 4-phase cycle (req up, ack up, req down, ack down) before arbitrating again. It sits in the sending core, facing the receiving core's two-flop-synchronized receiver across the clock-domain boundary.

## Interface
- DATA_WIDTH, 8, width of one link word
- NUM_SRC, 4, number of requesters (2..8)
- TIMEOUT, 255, maximum cycles in REQ waiting for ack; 0 disables timeout (8-bit counter)

- clk  in  1  single clock
- reset  in  1  synchronous, active-high; all state cleared on the clk edge where it is sampled high
- src_valid  in  NUM_SRC  requester i has a word pending; held until its src_done
- src_data  in  NUM_SRC*DATA_WIDTH  word of requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- src_done  out  NUM_SRC  one-cycle pulse to the served requester when its transfer finishes
- src_err  out  1  one-cycle pulse with src_done when the transfer ended by timeout
- link_req  out  1  4-phase request to the remote receiver (registered)
- link_data  out  DATA_WIDTH  bundled data (registered), stable from one cycle before link_req rises until after ack falls
- link_ack  in  1  asynchronous acknowledge from the remote receiver
- grant_id  out  clog2(NUM_SRC)  index of the requester currently being served
- busy  out  1  high in every state except IDLE

## Operation
- Reset values: link_req=0, link_data=0, grant_id=0, busy=0, src_done=0, src_err=0, both ack sync flops=0, round-robin pointer ptr=0, timeout counter=0, state=IDLE.
- ack_s = link_ack after two clk flops; the FSM uses only ack_s.
- FSM states: IDLE, LOAD, REQ, RELEASE.
- IDLE: if any src_valid is high and src_done was not pulsed this cycle, choose the first set bit searching ptr, ptr+1, ..., NUM_SRC-1, 0, ..., ptr-1. Then grant_id <= winner, link_data <= src_data[winner], and go to LOAD. Otherwise stay.
- LOAD: one cycle for bundled-data setup. link_req <= 1, counter <= 0, go to REQ.
- REQ: if ack_s=1, link_req <= 0 and go to RELEASE. Else if TIMEOUT!=0 and counter==TIMEOUT, link_req <= 0, set the internal err flag, and go to RELEASE. Else counter increments.
- RELEASE: wait for ack_s=0. Then go to IDLE; src_done[grant_id] pulses and src_err=err flag, both for the next cycle. ptr <= (grant_id+1) mod NUM_SRC; err flag cleared.
- Done-cycle guard: in the IDLE cycle where src_done is high, no arbitration takes place. The served source drops src_valid in this cycle.
- A src_valid deasserted mid-transfer is ignored: the latched word completes. Only IDLE samples src_valid and src_data.
- A timeout also advances ptr, so a stuck link does not starve other requesters.
- link_data holds its value in IDLE. It changes only on the IDLE->LOAD edge.
- Reset mid-transfer returns to IDLE with link_req=0 on that edge, and no src_done is issued. The remote side sees a request withdrawal.
- An ack_s that is already high in LOAD (a protocol violation) is ignored until REQ.

## Timing
- src_valid high at edge t (IDLE): link_data valid after t+1, link_req high after t+2.
- link_ack rises: ack_s high 2 edges later, link_req falls on the 3rd edge.
- link_ack falls: ack_s low 2 edges later, state enters IDLE with src_done on the 3rd edge.
- Minimum cycle for back-to-back transfers: next LOAD starts 2 edges after the src_done edge (done cycle, then the IDLE arbitration edge).
- Timeout: link_req falls TIMEOUT+1 edges after entering REQ.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Single source: NUM_SRC=4, src_valid=4'b0100, data 8'hA5; responder acks after 5 cycles. Expect link_data=A5 one cycle before link_req, grant_id=2, src_done=4'b0100 once, src_err=0.
- Round-robin: all four valid continuously with distinct data. Expect grant order 0,1,2,3,0, with ptr advancing after each done. No source is served twice before all are served.
- Timeout: TIMEOUT=10, responder never acks. Expect link_req high exactly 11 cycles, then src_done with src_err=1, then the next requester is granted.
- Mid-transfer drop: the source deasserts src_valid in REQ. Expect the transfer to complete with the original data and src_done to pulse.
- Reset in REQ: assert reset one cycle. Expect link_req=0, busy=0, grant_id=0, no src_done; a fresh transfer afterwards proceeds normally from ptr=0.
- Ack glitch timing: ack rises and falls with 1-cycle spacing, asynchronous to clk. Expect no skipped phase, exactly one src_done, and link_req never re-asserted before ack_s=0.

Source files
------------

// File: rtl/link_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : link_arbiter_if
// Brief  : Requester-side and link-side signal bundle for link_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface link_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4
);
    localparam int c_id_w = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0]            src_valid;
    logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]            src_done;
    logic                          src_err;
    logic                          link_req;
    logic [DATA_WIDTH-1:0]         link_data;
    logic                          link_ack;
    logic [c_id_w-1:0]             grant_id;
    logic                          busy;

    modport master (
        input  src_valid, src_data, link_ack,
        output src_done, src_err, link_req, link_data, grant_id, busy
    );

    modport slave (
        output src_valid, src_data, link_ack,
        input  src_done, src_err, link_req, link_data, grant_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/link_arbiter.sv
`default_nettype none
// ============================================================================
// Module : link_arbiter
// Brief  : Round-robin arbiter sharing one 4-phase bundled-data link.
// Rev    : 1.0  initial release
// ============================================================================
module link_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SRC    = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic           clk,
    input  logic           reset,
    link_arbiter_if.master bus
);
    localparam int                c_id_w       = $clog2(NUM_SRC);
    localparam logic [7:0]        c_timeout    = 8'(TIMEOUT);
    localparam logic              c_timeout_en = (TIMEOUT != 0);
    localparam logic [c_id_w-1:0] c_last       = c_id_w'(NUM_SRC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_REQ     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_ack_meta, r_ack_s;
    logic [c_id_w-1:0]       r_ptr, w_ptr_nxt;
    logic [c_id_w-1:0]       r_grant_id, w_grant_id_nxt;
    logic [c_id_w-1:0]       w_winner;
    logic [c_id_w:0]         w_idx;
    logic                    w_found;
    logic [7:0]              r_cnt, w_cnt_nxt;
    logic                    r_err, w_err_nxt;
    logic                    r_link_req, w_link_req_nxt;
    logic [DATA_WIDTH-1:0]   r_link_data, w_link_data_nxt, w_win_data;
    logic [NUM_SRC-1:0]      r_src_done, w_src_done_nxt, w_grant_onehot;
    logic                    r_src_err, w_src_err_nxt;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (c_id_w + 1)'(k);
            if (w_idx >= (c_id_w + 1)'(NUM_SRC)) begin
                w_idx = w_idx - (c_id_w + 1)'(NUM_SRC);
            end
            if (bus.src_valid[w_idx[c_id_w-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[c_id_w-1:0];
            end
        end
    end

    always_comb begin
        w_win_data     = '0;
        w_grant_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_winner == c_id_w'(i)) begin
                w_win_data = bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            w_grant_onehot[i] = (r_grant_id == c_id_w'(i));
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_grant_id_nxt  = r_grant_id;
        w_link_data_nxt = r_link_data;
        w_link_req_nxt  = r_link_req;
        w_cnt_nxt       = r_cnt;
        w_err_nxt       = r_err;
        w_src_done_nxt  = '0;
        w_src_err_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The done cycle is skipped so the served source can drop its valid.
                if (w_found && !(|r_src_done)) begin
                    w_grant_id_nxt  = w_winner;
                    w_link_data_nxt = w_win_data;
                    w_state_nxt     = S_LOAD;
                end
            end
            S_LOAD: begin
                w_link_req_nxt = 1'b1;
                w_cnt_nxt      = '0;
                w_state_nxt    = S_REQ;
            end
            S_REQ: begin
                if (r_ack_s) begin
                    w_link_req_nxt = 1'b0;
                    w_state_nxt    = S_RELEASE;
                end else if (c_timeout_en && (r_cnt == c_timeout)) begin
                    w_link_req_nxt = 1'b0;
                    w_err_nxt      = 1'b1;
                    w_state_nxt    = S_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_RELEASE: begin
                if (!r_ack_s) begin
                    w_state_nxt    = S_IDLE;
                    w_src_done_nxt = w_grant_onehot;
                    w_src_err_nxt  = r_err;
                    w_err_nxt      = 1'b0;
                    w_ptr_nxt      = (r_grant_id == c_last) ? '0 : r_grant_id + c_id_w'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ack_meta  <= 1'b0;
            r_ack_s     <= 1'b0;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_link_req  <= 1'b0;
            r_link_data <= '0;
            r_src_done  <= '0;
            r_src_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ack_meta  <= bus.link_ack;
            r_ack_s     <= r_ack_meta;
            r_ptr       <= w_ptr_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err       <= w_err_nxt;
            r_link_req  <= w_link_req_nxt;
            r_link_data <= w_link_data_nxt;
            r_src_done  <= w_src_done_nxt;
            r_src_err   <= w_src_err_nxt;
        end
    end

    assign bus.link_req  = r_link_req;
    assign bus.link_data = r_link_data;
    assign bus.grant_id  = r_grant_id;
    assign bus.src_done  = r_src_done;
    assign bus.src_err   = r_src_err;
    assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_link_arbiter
// Brief  : Self-checking bench for link_arbiter with a transfer-timeline model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_link_arbiter;
    localparam int DW = 8;
    localparam int NS = 4;
    localparam int TO = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    link_arbiter_if #(.DATA_WIDTH(DW), .NUM_SRC(NS)) bus ();

    link_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: a transfer is a timeline of grant, req rise, req fall, done.
    int         m_ptr, m_grant, m_rise, m_cyc;
    bit         m_busy, m_raised, m_req, m_to, m_err;
    bit         m_hist0, m_hist1;
    logic [7:0] m_data;
    logic [3:0] m_done;

    always @(posedge clk) begin
        bit ack_seen;
        bit done_prev;
        ack_seen = m_hist1;
        m_hist1  = m_hist0;
        m_hist0  = bus.link_ack;
        if (reset) begin
            m_ptr = 0; m_grant = 0; m_busy = 0; m_raised = 0; m_req = 0;
            m_to = 0; m_err = 0; m_data = '0; m_done = '0;
            m_hist0 = 0; m_hist1 = 0;
        end else begin
            done_prev = (m_done != 0);
            m_done = '0;
            m_err  = 0;
            if (!m_busy) begin
                if (bus.src_valid != 0 && !done_prev) begin
                    for (int k = 0; k < NS; k++) begin
                        int s;
                        s = (m_ptr + k) % NS;
                        if (bus.src_valid[s]) begin
                            m_grant = s;
                            break;
                        end
                    end
                    m_data   = bus.src_data[m_grant*DW +: DW];
                    m_busy   = 1;
                    m_raised = 0;
                end
            end else if (!m_raised) begin
                m_raised = 1;
                m_req    = 1;
                m_rise   = m_cyc;
            end else if (m_req) begin
                if (ack_seen) m_req = 0;
                else if (TO != 0 && (m_cyc - m_rise) == TO + 1) begin
                    m_req = 0;
                    m_to  = 1;
                end
            end else if (!ack_seen) begin
                m_busy = 0;
                m_done = 4'(1 << m_grant);
                m_err  = m_to;
                m_to   = 0;
                m_ptr  = (m_grant + 1) % NS;
            end
        end
        m_cyc++;
    end

    bit         prev_req;
    logic [7:0] prev_data;
    int         run_len, last_len;

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_model",
                  {bus.link_req, bus.busy, bus.src_err, bus.src_done, bus.grant_id, bus.link_data},
                  {m_req, m_busy, m_err, m_done, 2'(m_grant), m_data});
            if (bus.link_req && !prev_req) check("data_setup", bus.link_data, prev_data);
        end
        if (bus.link_req) run_len++;
        else begin
            if (prev_req) last_len = run_len;
            run_len = 0;
        end
        prev_req  = bus.link_req;
        prev_data = bus.link_data;
    end

    int resp_mode = 0;   // 0: 4-phase responder, 1: never acks, 2: one-cycle ack pulse
    int rdelay    = 0;
    int rcnt      = 0;
    bit pulsed    = 0;
    int refill_en = 0;   // 0: none, 1: always, 2: random

    task automatic tick();
        logic nack;
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            if (bus.src_done[i]) bus.src_valid[i] = 1'b0;
            else if (!bus.src_valid[i] && (refill_en == 1 || (refill_en == 2 && $urandom_range(2, 0) == 0))) begin
                bus.src_valid[i] = 1'b1;
                bus.src_data[i*DW +: DW] = 8'($urandom);
            end
        end
        nack = bus.link_ack;
        case (resp_mode)
            0: begin
                if (!bus.link_ack && bus.link_req) begin
                    if (rcnt >= rdelay) begin nack = 1'b1; rcnt = 0; end else rcnt++;
                end else if (bus.link_ack && !bus.link_req) begin
                    if (rcnt >= rdelay) begin nack = 1'b0; rcnt = 0; end else rcnt++;
                end
            end
            1: nack = 1'b0;
            default: begin
                if (bus.link_ack) nack = 1'b0;
                else if (bus.link_req && !pulsed) begin nack = 1'b1; pulsed = 1; end
                if (!bus.link_req) pulsed = 0;
            end
        endcase
        #($urandom_range(3, 1));
        bus.link_ack = nack;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (!(|bus.src_done) && n < budget) begin tick(); n++; end
        check({name, "_done_seen"}, 32'(|bus.src_done), 32'd1);
    endtask

    task automatic wait_req(input int budget, input string name);
        int n;
        n = 0;
        while (!bus.link_req && n < budget) begin tick(); n++; end
        check({name, "_req_seen"}, 32'(bus.link_req), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin tick(); n++; end
        check("idle_reached", 32'(bus.busy), 32'd0);
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int exp_rr[5];
        int cnt;
        logic err_seen;
        exp_rr = '{0, 1, 2, 3, 0};
        bus.src_valid = '0;
        bus.src_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.link_ack  = 1'b0;
        repeat (3) tick();
        reset  = 1'b0;
        chk_en = 1'b1;
        check("reset_state",
              {bus.link_req, bus.busy, bus.src_err, bus.src_done, bus.grant_id, bus.link_data}, 32'd0);

        // Single source, slow responder
        resp_mode = 0; rdelay = 5;
        bus.src_data[2*DW +: DW] = 8'hA5;
        bus.src_valid = 4'b0100;
        wait_done(100, "single");
        check("single_grant", 32'(bus.grant_id), 32'd2);
        check("single_done", 32'(bus.src_done), 32'h4);
        check("single_err", 32'(bus.src_err), 32'd0);
        check("single_data", 32'(bus.link_data), 32'hA5);
        cnt = 0;
        repeat (15) begin tick(); if (|bus.src_done) cnt++; end
        check("single_once", 32'(cnt), 32'd0);

        // Round robin with every source continuously requesting
        do_reset();
        rdelay = 1; refill_en = 1;
        bus.src_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.src_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(100, "rr");
            check("rr_order", 32'(bus.grant_id), 32'(exp_rr[k]));
            if (k == 4) begin refill_en = 0; bus.src_valid = '0; end
            else tick();
        end
        wait_idle(100);

        // Timeout, then the next requester is served normally
        do_reset();
        resp_mode = 1;
        bus.src_valid = 4'b0011;
        wait_done(100, "timeout");
        check("to_err", 32'(bus.src_err), 32'd1);
        check("to_grant", 32'(bus.grant_id), 32'd0);
        check("to_req_len", 32'(last_len), 32'd11);
        resp_mode = 0; rdelay = 2;
        tick();
        wait_done(100, "after_to");
        check("after_to_grant", 32'(bus.grant_id), 32'd1);
        check("after_to_err", 32'(bus.src_err), 32'd0);
        wait_idle(100);

        // Source withdraws and alters its word mid-transfer
        bus.src_data[3*DW +: DW] = 8'h3C;
        bus.src_valid = 4'b1000;
        wait_req(20, "drop");
        bus.src_valid[3] = 1'b0;
        bus.src_data[3*DW +: DW] = 8'hC3;
        wait_done(100, "drop");
        check("drop_grant", 32'(bus.grant_id), 32'd3);
        check("drop_data", 32'(bus.link_data), 32'h3C);
        wait_idle(100);

        // Reset while the request is outstanding
        resp_mode = 1;
        bus.src_valid = 4'b0010;
        wait_req(20, "rst_mid");
        tick(); tick();
        do_reset();
        check("rst_mid_state", {bus.link_req, bus.busy, bus.grant_id, bus.src_done}, 32'd0);
        bus.src_valid[3] = 1'b1;
        resp_mode = 0; rdelay = 3;
        wait_done(100, "post_rst");
        check("post_rst_grant", 32'(bus.grant_id), 32'd1);
        tick();
        wait_done(100, "post_rst2");
        check("post_rst2_grant", 32'(bus.grant_id), 32'd3);
        wait_idle(100);

        // One-cycle ack pulse
        resp_mode = 2;
        bus.src_valid = 4'b0100;
        cnt = 0; err_seen = 1'b0;
        repeat (40) begin
            tick();
            if (|bus.src_done) begin cnt++; err_seen = bus.src_err; end
        end
        check("glitch_done_cnt", 32'(cnt), 32'd1);
        check("glitch_err", 32'(err_seen), 32'd0);

        // Random traffic against the model
        refill_en = 2;
        for (int blk = 0; blk < 8; blk++) begin
            int r;
            r = $urandom_range(5, 0);
            resp_mode = (r == 0) ? 1 : ((r < 3) ? 2 : 0);
            rdelay = $urandom_range(4, 0);
            repeat (50) tick();
        end
        refill_en = 0; resp_mode = 0; rdelay = 0;
        bus.src_valid = '0;
        wait_idle(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end
endmodule
`default_nettype wire
